gol_sequencer: RTL and testbench

Sequencer for the Game-of-Life row register file (`prev_state`). It owns that file's `ra`/`wd`/`regwrite` port and loads an initial board from a host stream. It then advances the board a requested number of generations in place and streams the board back out. In-place update is safe because new rows are buffered and written back one row behind the compute pointer. Next-row logic lives in a combinational child module.

---
 rtl/gol_pkg.sv | 23 ++
 rtl/gol_row_next.sv | 44 ++++
 rtl/gol_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_gol_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and rule constants for the Game-of-Life sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gol_pkg;

  // Sequencer states: idle, host load, per-row compute, row write-back,
  // last-row write-back, host dump.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_COMP = 3'd2,
    S_WRB  = 3'd3,
    S_WRL  = 3'd4,
    S_DUMP = 3'd5
  } gol_seq_state_t;

  // Conway rules: a dead cell with 3 live neighbours is born,
  // a live cell with 2 or 3 live neighbours survives.
  localparam logic [3:0] BIRTH_CNT  = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

endpackage

// File: rtl/gol_row_next.sv
// Next-generation value of one board row from that row and its two vertical neighbours.
// Latency: combinational.
// Backpressure: none.
// Ports: above/cur/below = rows r-1, r, r+1 (WIDTH bits); nxt = row r of the next generation.
// Config: GOL_TORUS_EN makes columns 0 and WIDTH-1 neighbours; otherwise off-board cells are dead.
import gol_pkg::*;

module gol_row_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] nxt
);

  // Rows padded by one cell at each end: cell i lives at index i+1.
  logic [WIDTH+1:0] ea, ec, eb;

`ifdef GOL_TORUS_EN
  assign ea = {above[0], above, above[WIDTH-1]};
  assign ec = {cur[0],   cur,   cur[WIDTH-1]};
  assign eb = {below[0], below, below[WIDTH-1]};
`else
  assign ea = {1'b0, above, 1'b0};
  assign ec = {1'b0, cur,   1'b0};
  assign eb = {1'b0, below, 1'b0};
`endif

  logic [3:0] cnt;

  always_comb begin
    nxt = '0;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = {3'b000, ea[i]} + {3'b000, ea[i+1]} + {3'b000, ea[i+2]}
          + {3'b000, ec[i]}                     + {3'b000, ec[i+2]}
          + {3'b000, eb[i]} + {3'b000, eb[i+1]} + {3'b000, eb[i+2]};
      nxt[i] = (cnt == BIRTH_CNT) ||
               (cur[i] && ((cnt == SURVIVE_LO) || (cnt == SURVIVE_HI)));
    end
  end

endmodule

// File: rtl/gol_sequencer.sv
// Loads, advances in place, and dumps a Game-of-Life board held in an external row register file.
// Latency: one row per handshake for load/dump; exactly 2N cycles per generation when stepping.
// Backpressure: load stalls on load_valid=0, dump stalls on dump_ready=0; commands only taken in IDLE.
// Ports: ph1 clock, reset (sync, active-high); load_start/step_start/dump_start commands with gen_cnt;
//   load_valid/load_ready/load_data and dump_valid/dump_ready/dump_data host streams; busy/done status;
//   ra/wd/regwrite drive the register file, row_a/row/row_b are its reads of rows ra-1, ra, ra+1.
// Config: GOL_TORUS_EN selects a toroidal board; default is a dead border.
import gol_pkg::*;

module gol_sequencer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 8
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               load_start,
  input  logic               step_start,
  input  logic               dump_start,
  input  logic [GENBITS-1:0] gen_cnt,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [WIDTH-1:0]   dump_data,
  output logic               busy,
  output logic               done,
  output logic [REGBITS-1:0] ra,
  output logic [WIDTH-1:0]   wd,
  output logic               regwrite,
  input  logic [WIDTH-1:0]   row_a,
  input  logic [WIDTH-1:0]   row,
  input  logic [WIDTH-1:0]   row_b
);

  localparam logic [REGBITS-1:0] KLAST = '1;  // row N-1
  localparam logic [REGBITS-1:0] KONE  = REGBITS'(1);

  gol_seq_state_t     state, state_nx;
  logic [REGBITS-1:0] k, k_nx;
  logic [GENBITS-1:0] gen_left, gen_left_nx;
  logic [WIDTH-1:0]   buf_old, buf_new;
  logic [WIDTH-1:0]   nbr_a, nbr_b, nxt;
  logic               done_q, done_nx;

  // Vertical neighbours fed to the row rule. Row N-1's lower neighbour is
  // row 0, which has already been overwritten by the time k reaches N-1,
  // so the torus build keeps a copy of the old row 0.
`ifdef GOL_TORUS_EN
  logic [WIDTH-1:0] row0_save;

  always_ff @(posedge ph1) begin
    if (reset)
      row0_save <= '0;
    else if (state == S_COMP && k == '0)
      row0_save <= row;
  end

  assign nbr_a = row_a;
  assign nbr_b = (k == KLAST) ? row0_save : row_b;
`else
  assign nbr_a = (k == '0)    ? '0 : row_a;
  assign nbr_b = (k == KLAST) ? '0 : row_b;
`endif

  gol_row_next #(.WIDTH(WIDTH)) u_row_next (
    .above (nbr_a),
    .cur   (row),
    .below (nbr_b),
    .nxt   (nxt)
  );

  always_ff @(posedge ph1) begin
    if (reset) begin
      state    <= S_IDLE;
      k        <= '0;
      gen_left <= '0;
      buf_old  <= '0;
      buf_new  <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      gen_left <= gen_left_nx;
      done_q   <= done_nx;
      if (state == S_COMP) begin
        buf_old <= buf_new;
        buf_new <= nxt;
      end
    end
  end

  assign busy = (state != S_IDLE);

  // Load, dump and zero-generation steps signal completion in the cycle
  // after they finish. A real step signals in its final WRL cycle so that
  // done lands exactly gen_cnt*2N cycles after step_start.
  assign done = done_q | ((state == S_WRL) && (gen_left == GENBITS'(1)));

  always_comb begin
    state_nx    = state;
    k_nx        = k;
    gen_left_nx = gen_left;
    done_nx     = 1'b0;
    load_ready  = 1'b0;
    dump_valid  = 1'b0;
    dump_data   = '0;
    ra          = '0;
    wd          = '0;
    regwrite    = 1'b0;

    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_nx = S_LOAD;
          k_nx     = '0;
        end else if (step_start) begin
          k_nx = '0;
          if (gen_cnt == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx    = S_COMP;
            gen_left_nx = gen_cnt;
          end
        end else if (dump_start) begin
          state_nx = S_DUMP;
          k_nx     = '0;
        end
      end

      S_LOAD: begin
        load_ready = 1'b1;
        ra         = k;
        wd         = load_data;
        regwrite   = load_valid;
        if (load_valid) begin
          k_nx = k + KONE;
          if (k == KLAST) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end

      // Row 0 has no write-back slot of its own; its result sits in the
      // buffer until the WRB that follows C1.
      S_COMP: begin
        ra = k;
        if (k == '0) begin
          k_nx = KONE;
        end else begin
          state_nx = S_WRB;
        end
      end

      S_WRB: begin
        ra       = k - KONE;
        wd       = buf_old;
        regwrite = 1'b1;
        if (k != KLAST) begin
          k_nx     = k + KONE;
          state_nx = S_COMP;
        end else begin
          state_nx = S_WRL;
        end
      end

      S_WRL: begin
        ra          = KLAST;
        wd          = buf_new;
        regwrite    = 1'b1;
        gen_left_nx = gen_left - GENBITS'(1);
        k_nx        = '0;
        state_nx    = (gen_left == GENBITS'(1)) ? S_IDLE : S_COMP;
      end

      S_DUMP: begin
        ra         = k;
        dump_valid = 1'b1;
        dump_data  = row;
        if (dump_ready) begin
          k_nx = k + KONE;
          if (k == KLAST) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gol_sequencer.sv
// Scoreboard bench for gol_sequencer with a behavioural register file and board model.
// Latency: n/a.
// Backpressure: randomised load_valid and dump_ready.
module tb_gol_sequencer;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int GENBITS = 8;
  localparam int N       = 8;

  logic               ph1 = 1'b0;
  logic               reset = 1'b1;
  logic               load_start = 1'b0;
  logic               step_start = 1'b0;
  logic               dump_start = 1'b0;
  logic [GENBITS-1:0] gen_cnt = '0;
  logic               load_valid = 1'b0;
  logic               load_ready;
  logic [WIDTH-1:0]   load_data = '0;
  logic               dump_valid;
  logic               dump_ready = 1'b0;
  logic [WIDTH-1:0]   dump_data;
  logic               busy;
  logic               done;
  logic [REGBITS-1:0] ra;
  logic [WIDTH-1:0]   wd;
  logic               regwrite;
  logic [WIDTH-1:0]   row_a, row, row_b;

  gol_sequencer #(.WIDTH(WIDTH), .REGBITS(REGBITS), .GENBITS(GENBITS)) dut (
    .ph1        (ph1),
    .reset      (reset),
    .load_start (load_start),
    .step_start (step_start),
    .dump_start (dump_start),
    .gen_cnt    (gen_cnt),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done),
    .ra         (ra),
    .wd         (wd),
    .regwrite   (regwrite),
    .row_a      (row_a),
    .row        (row),
    .row_b      (row_b)
  );

  always #5 ph1 = ~ph1;

  int cyc = 0;
  always @(posedge ph1) cyc <= cyc + 1;

  // Register file: written in the second half of the cycle, read combinationally.
  logic [WIDTH-1:0] rf [N] = '{default: 8'h00};
  logic [REGBITS-1:0] ra_m1, ra_p1;
  assign ra_m1 = ra - 3'd1;
  assign ra_p1 = ra + 3'd1;
  assign row   = rf[ra];
  assign row_a = rf[ra_m1];
  assign row_b = rf[ra_p1];
  always @(negedge ph1) if (regwrite) rf[ra] <= wd;

  int checks = 0;
  int failures = 0;
  int rw_count = 0;

  logic [WIDTH-1:0] stim  [N];
  logic [WIDTH-1:0] model [N];
  int               exp_done_q[$];
  logic [WIDTH-1:0] exp_dump_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals done or completes a dump beat.
  always @(negedge ph1) begin
    if (regwrite) rw_count++;
    if (!reset) begin
      if (done) begin
        if (exp_done_q.size() == 0) check("done_spurious", 1, 0);
        else check("done_cycle", cyc, exp_done_q.pop_front());
      end
      if (dump_valid && dump_ready) begin
        if (exp_dump_q.size() == 0) check("dump_spurious", 1, 0);
        else check("dump_row", int'(dump_data), int'(exp_dump_q.pop_front()));
      end
    end
  end

  // Reference model: one generation from the life rules over the whole board.
  function automatic void model_step();
    logic [WIDTH-1:0] nb [N];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef GOL_TORUS_EN
            rr = (rr + N) % N;
            cc = (cc + WIDTH) % WIDTH;
            n += model[rr][cc];
`else
            if (rr >= 0 && rr < N && cc >= 0 && cc < WIDTH) n += model[rr][cc];
`endif
          end
        end
        nb[r][c] = model[r][c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    for (int r = 0; r < N; r++) model[r] = nb[r];
  endfunction

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic drained(input string name);
    check({name, "_done_pending"}, exp_done_q.size(), 0);
    check({name, "_dump_pending"}, exp_dump_q.size(), 0);
    exp_done_q.delete();
    exp_dump_q.delete();
  endtask

  task automatic do_load(input bit with_step);
    int r, guard;
    load_start = 1'b1;
    step_start = with_step;
    gen_cnt    = 8'd1;
    tick();
    load_start = 1'b0;
    step_start = 1'b0;
    if (with_step) check("load_wins_ready", int'(load_ready), 1);
    r = 0;
    guard = 0;
    while (r < N && guard < 400) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = load_valid ? stim[r] : WIDTH'($urandom);
      if (load_valid) begin
        if (r == N - 1) exp_done_q.push_back(cyc + 1);
        r++;
      end
      tick();
      guard++;
    end
    load_valid = 1'b0;
    check("load_guard", int'(r == N), 1);
    for (int m = 0; m < N; m++) model[m] = stim[m];
    tick();
    tick();
    drained("load");
  endtask

  task automatic do_step(input int g);
    int c, rw0;
    gen_cnt    = GENBITS'(g);
    step_start = 1'b1;
    c   = cyc;
    rw0 = rw_count;
    exp_done_q.push_back(g == 0 ? c + 1 : c + 2 * N * g);
    tick();
    step_start = 1'b0;
    check("step_busy", int'(busy), int'(g != 0));
    for (int i = 0; i < g; i++) model_step();
    repeat (2 * N * g + 3) tick();
    if (g == 0) check("gen0_no_writes", rw_count - rw0, 0);
    else check("step_write_count", rw_count - rw0, N * g);
    drained("step");
  endtask

  task automatic do_dump();
    int r, guard;
    for (int m = 0; m < N; m++) exp_dump_q.push_back(model[m]);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    r = 0;
    guard = 0;
    while (r < N && guard < 400) begin
      dump_ready = $urandom_range(0, 1) != 0;
      if (dump_ready) begin
        if (r == N - 1) exp_done_q.push_back(cyc + 1);
        r++;
      end
      tick();
      guard++;
    end
    dump_ready = 1'b0;
    check("dump_guard", int'(r == N), 1);
    tick();
    tick();
    drained("dump");
  endtask

  task automatic clear_stim();
    for (int m = 0; m < N; m++) stim[m] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, rw0;
    // Reset held for two edges.
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy",       int'(busy), 0);
    check("rst_done",       int'(done), 0);
    check("rst_load_ready", int'(load_ready), 0);
    check("rst_dump_valid", int'(dump_valid), 0);
    check("rst_regwrite",   int'(regwrite), 0);
    check("rst_ra",         int'(ra), 0);
    check("rst_wd",         int'(wd), 0);
    check("rst_dump_data",  int'(dump_data), 0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", int'(busy), 0);

    // Blinker.
    clear_stim();
    stim[3] = 8'h1C;
    do_load(1'b0);
    do_step(1);
    do_dump();

    // Three cells on the top edge.
    clear_stim();
    stim[0] = 8'h07;
    do_load(1'b0);
    do_step(1);
    do_dump();

`ifdef GOL_TORUS_EN
    // Glider travels all the way round the torus.
    clear_stim();
    stim[0] = 8'h02;
    stim[1] = 8'h04;
    stim[2] = 8'h07;
    do_load(1'b0);
    do_step(32);
    do_dump();
`endif

    // Zero generations: no writes, done next cycle.
    do_step(0);
    do_dump();

    // Coincident load and step: load wins.
    for (int m = 0; m < N; m++) stim[m] = WIDTH'($urandom);
    do_load(1'b1);
    do_dump();

    // Random boards and generation counts.
    for (int t = 0; t < 6; t++) begin
      for (int m = 0; m < N; m++) stim[m] = WIDTH'($urandom);
      do_load(1'b0);
      do_step($urandom_range(0, 3));
      do_dump();
    end

    // Reset while computing row 1 of the first generation: nothing written yet.
    for (int m = 0; m < N; m++) stim[m] = WIDTH'($urandom);
    do_load(1'b0);
    gen_cnt    = 8'd1;
    step_start = 1'b1;
    c   = cyc;
    rw0 = rw_count;
    tick();
    step_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("midrst_busy",     int'(busy), 0);
    check("midrst_regwrite", int'(regwrite), 0);
    reset = 1'b0;
    tick();
    check("midrst_no_writes", rw_count - rw0, 0);
    check("midrst_elapsed", cyc - c, 4);
    do_dump();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
